game_countdown_timer: RTL
=========================

// Module: game_countdown_timer
// PURPOSE
//  Generates the game's seconds countdown that drives the 3-digit timer display (10-bit value, 0..999).
//  Divides the system clock to a 1 Hz tick and decrements the count while the game runs.
//  Accepts start, pause and reload controls plus a bonus-time event from game logic.
//  Flags expiry to the game FSM.
// PARAMETERS
//  CLK_HZ         50_000_000  system clock frequency; one tick every CLK_HZ cycles (sim uses 4)
//  START_SECONDS  60          value loaded at reset and on reload; must be <= 999
//  BONUS_SECONDS  5           seconds added per bonus_add pulse
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   synchronous reset, active-low
//  start      in   1   1-cycle pulse: begin countdown from IDLE
//  pause      in   1   1-cycle pulse: toggle RUN <-> PAUSED
//  reload     in   1   1-cycle pulse: abort, reload START_SECONDS, go IDLE
//  bonus_add  in   1   1-cycle pulse: add BONUS_SECONDS, saturating at 999
//  timer      out  10  current seconds remaining, feeds the display block
//  running    out  1   high only in RUN
//  expired    out  1   1-cycle pulse on entering DONE
//  game_over  out  1   level, high in DONE
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state=IDLE, timer=START_SECONDS, prescaler=0, running=0,
//   expired=0, game_over=0. Takes priority over all inputs.
//  States: IDLE, RUN, PAUSED, DONE. Control priority per cycle: reload > start > pause.
//  IDLE:   start -> RUN, prescaler cleared. If timer==0 at start -> DONE, expired pulses next cycle.
//  RUN:    prescaler counts 0..CLK_HZ-1; tick asserted in the cycle it equals CLK_HZ-1, then it wraps to 0.
//          On tick, timer decrements. 1->0 transition: next state DONE; expired=1 for exactly one cycle,
//          registered, coincident with the first DONE cycle.
//          pause -> PAUSED.
//  PAUSED: prescaler and timer frozen; pause -> RUN, resuming the prescaler from its held value.
//  DONE:   timer holds 0; start, pause and bonus_add ignored; only reload or rst leave DONE.
//  reload (any state): timer=START_SECONDS, prescaler=0, state=IDLE, expired not asserted.
//  bonus_add: accepted in IDLE, RUN and PAUSED.
//   timer = min(timer + BONUS_SECONDS, 999).
//   With tick in the same cycle: timer = min(timer + BONUS_SECONDS, 999) - 1, and no expiry.
//   Apply saturation with 11-bit intermediate arithmetic.
//  Latency: every control takes effect on the next clk edge. Outputs are registered, not combinational.
//  timer never underflows below 0 and never exceeds 999.
// STRUCTURE
//  Shared package (game_pkg): 2-bit state encoding constants
//   (ST_IDLE=0, ST_RUN=1, ST_PAUSED=2, ST_DONE=3), MAX_SECONDS=999, TIMER_W=10.
//  Sub-module tick_prescaler (clk, rst, en, clr -> tick), CLK_HZ parameter,
//   counter width $clog2(CLK_HZ); en=running, clr=start|reload.
//  Top holds the FSM, the timer register and the saturating add/decrement datapath.
// TESTING (CLK_HZ=4, START_SECONDS=3, BONUS_SECONDS=5)
//  1. rst low 2 cycles, release -> timer=3, running=0, game_over=0. start -> timer 3,2,1,0 at
//     4-cycle intervals; expired high exactly 1 cycle; game_over stays 1.
//  2. Pause: start, 2 cycles, pause, hold 20 cycles -> timer stays 3. pause again -> 2 after 2 more cycles.
//  3. Bonus saturation: preload via bonus_add x200 in IDLE -> timer=999, no wrap.
//     bonus in the same cycle as a tick at timer=1 -> timer=5, no expiry.
//  4. Reload mid-RUN at timer=2 -> next cycle timer=3, state IDLE, expired=0.
//     Start in DONE is ignored until a reload is applied.
//  5. rst asserted mid-RUN with start high in the same cycle -> reset values win.
//     Simultaneous reload+start -> IDLE.
//  6. Scoreboard: reference model compares timer/expired every cycle over 10k random control pulses.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game countdown timer.
//   state_e      : FSM state encoding
//   TIMER_W      : width of the seconds value shown on the display
//   MAX_SECONDS  : largest value the 3-digit display can show
//   sat_add      : add two seconds values using an 11-bit sum, clamped to MAX_SECONDS
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int TIMER_W     = 10;
  localparam int MAX_SECONDS = 999;

  function automatic logic [TIMER_W-1:0] sat_add(input logic [TIMER_W-1:0] a,
                                                 input logic [TIMER_W-1:0] b);
    logic [TIMER_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > (TIMER_W+1)'(MAX_SECONDS)) begin
      return TIMER_W'(MAX_SECONDS);
    end
    return sum[TIMER_W-1:0];
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
//   clk  : system clock
//   rst  : synchronous reset, active-low
//   en   : count enable; the count is held while low
//   clr  : return the count to zero (wins over en)
//   tick : high while enabled and the count sits at CLK_HZ-1
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // Keep at least one bit so CLK_HZ=1 still elaborates (tick every enabled cycle).
  localparam int              CNT_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Seconds countdown for the game's 3-digit timer display.
//   clk       : system clock
//   rst       : synchronous reset, active-low
//   start     : pulse, begin counting down from IDLE
//   pause     : pulse, toggle RUN <-> PAUSED
//   reload    : pulse, reload START_SECONDS and return to IDLE (any state)
//   bonus_add : pulse, add BONUS_SECONDS (saturating at 999) outside DONE
//   timer     : seconds remaining
//   running   : high in RUN
//   expired   : one-cycle pulse in the first DONE cycle
//   game_over : high in DONE
//
// state  | meaning
// IDLE   | loaded, waiting for start
// RUN    | prescaler enabled, timer decrements on each tick
// PAUSED | prescaler and timer frozen
// DONE   | timer reached zero; only reload or rst leave
module game_countdown_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int START_SECONDS = 60,
  parameter int BONUS_SECONDS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               reload,
  input  logic               bonus_add,
  output logic [TIMER_W-1:0] timer,
  output logic               running,
  output logic               expired,
  output logic               game_over
);

  localparam logic [TIMER_W-1:0] START_V = TIMER_W'(START_SECONDS);
  // Clamp up front so an oversized bonus cannot be truncated into a small one.
  localparam logic [TIMER_W-1:0] BONUS_V =
    TIMER_W'((BONUS_SECONDS > MAX_SECONDS) ? MAX_SECONDS : BONUS_SECONDS);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               running_q, running_d;
  logic               expired_q, expired_d;
  logic               game_over_q, game_over_d;

  logic               tick;
  logic               bonus_ok;
  logic [TIMER_W-1:0] timer_sum;

  tick_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (running_q),
    .clr  (start | reload),
    .tick (tick)
  );

  assign bonus_ok  = bonus_add && (state_q != ST_DONE);
  assign timer_sum = bonus_ok ? sat_add(timer_q, BONUS_V) : timer_q;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    expired_d = 1'b0;

    if (reload) begin
      state_d = ST_IDLE;
      timer_d = START_V;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = timer_sum;
          if (start) begin
            if (timer_sum == '0) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          timer_d = timer_sum;
          if (tick && (timer_sum != '0)) begin
            timer_d = timer_sum - 1'b1;
          end
          // Expiry beats a simultaneous pause; a bonus in the tick cycle keeps timer_sum above 1.
          if (tick && (timer_sum == TIMER_W'(1))) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          timer_d = timer_sum;
          if (pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          timer_d = '0;
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = START_V;
        end
      endcase
    end

    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= START_V;
      running_q   <= 1'b0;
      expired_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      running_q   <= running_d;
      expired_q   <= expired_d;
      game_over_q <= game_over_d;
    end
  end

  assign timer     = timer_q;
  assign running   = running_q;
  assign expired   = expired_q;
  assign game_over = game_over_q;

endmodule
